// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes and a
// single-entry registered output buffer. Shifts run one bit per cycle.
// Optional macro ALU_FAST_SHIFT_EN replaces the iterative shifter with a
// combinational barrel shifter, giving every op a 1-cycle latency.
module alu_exec_unit #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    logic [SHW-1:0]  shamt;
    logic            is_legal;
    logic            out_free;
    logic            accept;
    logic [XLEN-1:0] alu_res;

    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            out_valid_q, out_valid_d;

    assign shamt    = src_b[SHW-1:0];
    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Legality decode of the op code
    always_comb begin
        is_legal = 1'b1;
        case (alu_control)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL,
            OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA: is_legal = 1'b1;
            default:                                 is_legal = 1'b0;
        endcase
    end

    // Single-cycle datapath; illegal codes fall through to zero
    always_comb begin
        alu_res = '0;
        case (alu_control)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
`else
            // Only a zero shift amount completes here; others go iterative
            OP_SLL, OP_SRL, OP_SRA: alu_res = src_a;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN

    assign in_ready = !reset && out_free;

    // Next-state: write the output buffer on accept, otherwise drain it
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            illegal_d   = !is_legal;
            out_valid_d = 1'b1;
        end
    end

    // Output buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

`else

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            left_q, left_d;
    logic            arith_q, arith_d;
    logic            is_shift;

    assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                      (alu_control == OP_SRA);
    assign in_ready = !reset && (state_q == IDLE) && out_free;

    // Next-state: accept into buffer or shifter, step the shifter, drain
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        arith_d     = arith_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && shamt != '0) begin
                        acc_d   = src_a;
                        cnt_d   = shamt;
                        left_d  = (alu_control == OP_SLL);
                        arith_d = (alu_control == OP_SRA);
                        state_d = SHIFT;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        illegal_d   = !is_legal;
                        out_valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    if (left_q)
                        acc_d = {acc_q[XLEN-2:0], 1'b0};
                    else
                        acc_d = {arith_q & acc_q[XLEN-1], acc_q[XLEN-1:1]};
                    cnt_d = cnt_q - 1'b1;
                end else if (out_free) begin
                    // Wait here until the buffer can take the shifted value
                    result_d    = acc_q;
                    zero_d      = (acc_q == '0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, shifter and output buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            arith_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            arith_q     <= arith_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

`endif

    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed scenarios plus randomized traffic checked
// against a behavioural ALU model and an in-order result scoreboard.
module tb_alu_exec_unit;
    localparam int XLEN = 32;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, SLL = 4'b0100, SLT = 4'b0110;
    localparam logic [3:0] SLTU = 4'b0111, SRL = 4'b1010, SRA = 4'b1011;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      alu_control = 4'b0;
    logic [XLEN-1:0] src_a = '0;
    logic [XLEN-1:0] src_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal_op(illegal_op)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();
    endtask

    // Reference: {illegal, zero, result} straight from the op-code table
    function automatic logic [XLEN+1:0] model(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic            ill;
        int              n;
        n   = int'(b % XLEN);
        r   = '0;
        ill = 1'b0;
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a << n;
            4'b0110: r[0] = ($signed(a) < $signed(b));
            4'b0111: r[0] = (a < b);
            4'b1000: r = a ^ b;
            4'b1010: r = a >> n;
            4'b1011: r = $signed(a) >>> n;
            default: ill = 1'b1;
        endcase
        return {ill, (r == '0), r};
    endfunction

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if ({out_valid, zero, illegal_op} !== 3'b000 || result !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b z=%b i=%b r=%h expected 0 0 0 0",
                     out_valid, zero, illegal_op, result);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1;
        alu_control = ADD; src_a = 32'h7FFF_FFFF; src_b = 32'd1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready0: got %b expected 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h8000_0000 || zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_add: got v=%b r=%h z=%b expected 1 80000000 0", out_valid, result, zero);
        end
        alu_control = SUB; src_a = 32'd5; src_b = 32'd5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready1: got %b expected 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sub: got v=%b r=%h z=%b expected 1 00000000 1", out_valid, result, zero);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_slt_sra();
        out_ready = 1'b1; in_valid = 1'b1;
        alu_control = SLT; src_a = 32'hFFFF_FFFF; src_b = 32'd1;
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd1) begin
            errors++; $display("FAIL slt: got v=%b r=%h expected 1 00000001", out_valid, result);
        end
        alu_control = SLTU;
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
            errors++; $display("FAIL sltu: got v=%b r=%h z=%b expected 1 00000000 1", out_valid, result, zero);
        end
        alu_control = SRA; src_a = 32'h8000_0000; src_b = 32'd4;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL sra_busy c%0d: got v=%b rdy=%b expected 0 0", i, out_valid, in_ready);
            end
            if (i < 4) step();
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hF800_0000 || illegal_op !== 1'b0) begin
            errors++; $display("FAIL sra: got v=%b r=%h expected 1 f8000000", out_valid, result);
        end
    endtask

    task automatic test_sll_stall();
        out_ready = 1'b0; in_valid = 1'b1;
        alu_control = SLL; src_a = 32'd1; src_b = 32'd31;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL sll_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 40; i++) begin
            step();
            checks++;
            if (i >= 32) begin
                if (out_valid !== 1'b1 || result !== 32'h8000_0000 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL sll_hold c%0d: got v=%b r=%h rdy=%b expected 1 80000000 0",
                             i, out_valid, result, in_ready);
                end
            end else if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL sll_busy c%0d: got v=%b rdy=%b expected 0 0", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL sll_xfer: got rdy=%b v=%b expected 1 1", in_ready, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL sll_clear: got v=%b expected 0", out_valid);
        end
        in_valid = 1'b1; alu_control = SLL; src_a = 32'h1234; src_b = 32'd0;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h1234) begin
            errors++; $display("FAIL sll0: got v=%b r=%h expected 1 00001234", out_valid, result);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] codes [2];
        codes[0] = 4'b1111;
        codes[1] = 4'b0101;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            alu_control = codes[i]; src_a = 32'd5; src_b = 32'd7;
            step();
            checks++;
            if (out_valid !== 1'b1 || result !== '0 || zero !== 1'b1 || illegal_op !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%b: got v=%b r=%h z=%b i=%b expected 1 0 1 1",
                         codes[i], out_valid, result, zero, illegal_op);
            end
        end
        alu_control = ADD; src_a = 32'd1; src_b = 32'd1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd2 || zero !== 1'b0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: got v=%b r=%h z=%b i=%b expected 1 2 0 0",
                     out_valid, result, zero, illegal_op);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        out_ready = 1'b1; in_valid = 1'b1;
        alu_control = SRL; src_a = 32'hFFFF_0000; src_b = 32'd20;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst: got v=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL midrst_pulse: got out_valid pulse=%b expected 0", seen);
        end
        in_valid = 1'b1; alu_control = ADD; src_a = 32'd2; src_b = 32'd3;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            errors++; $display("FAIL midrst_add: got v=%b r=%h expected 1 00000005", out_valid, result);
        end
    endtask

    task automatic test_random();
        logic [XLEN+1:0] q [$];
        logic [XLEN+1:0] exp_v;
        logic [XLEN+1:0] held;
        logic            stalled;
        logic            acc;
        logic            xfer;
        int              ops;
        ops = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 20000 && ops < 300; cyc++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            alu_control = 4'($urandom_range(0, 15));
            src_a       = pick();
            src_b       = pick();
            out_ready   = ($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got r=%h with nothing expected", result);
                end else begin
                    exp_v = q.pop_front();
                    if ({illegal_op, zero, result} !== exp_v) begin
                        errors++;
                        $display("FAIL rand_result: got i=%b z=%b r=%h expected i=%b z=%b r=%h",
                                 illegal_op, zero, result, exp_v[XLEN+1], exp_v[XLEN], exp_v[XLEN-1:0]);
                    end
                end
            end
            if (acc) begin
                q.push_back(model(alu_control, src_a, src_b));
                ops++;
            end
            stalled = out_valid && !out_ready;
            held    = {illegal_op, zero, result};
            step();
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {illegal_op, zero, result} !== held) begin
                    errors++;
                    $display("FAIL rand_stable: got v=%b r=%h expected 1 %h", out_valid, result, held[XLEN-1:0]);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_drain_spurious: got r=%h", result);
                end else begin
                    exp_v = q.pop_front();
                    if ({illegal_op, zero, result} !== exp_v) begin
                        errors++;
                        $display("FAIL rand_drain: got r=%h expected %h", result, exp_v[XLEN-1:0]);
                    end
                end
            end
            step();
        end
        checks++;
        if (ops != 300 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_progress: got ops=%0d pending=%0d expected 300 0", ops, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_slt_sra();
        drain();
        test_sll_stall();
        drain();
        test_illegal();
        drain();
        test_reset_mid_shift();
        drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
